bram_dump_reader: RTL and testbench

- Debug readout engine for the data BRAM. It is the read-side counterpart of the bench/host path that loads memory through the write port.
- On a start request it walks a word-aligned address range through the BRAM debug read port. Each word is emitted on a valid/ready stream, with a last flag and a running 32-bit checksum.
- It sits beside D_MEM, drives debug_addr, and feeds a host link or bench monitor. It never touches the CPU-side ports.

---
 rtl/bram_dump_reader_pkg.sv | 15 +
 rtl/bram_dump_reader_checksum.sv | 30 +++
 rtl/bram_dump_reader.sv | 133 +++++++++++++
 tb/tb_bram_dump_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_dump_reader_pkg.sv
// Shared definitions for the data-BRAM debug dump reader: FSM encodings and
// the address stride between consecutive words.
package bram_dump_reader_pkg;

  localparam int DUMP_DATA_WIDTH = 32;
  localparam int WORD_BYTES      = 4;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_READ = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/bram_dump_reader_checksum.sv
// Clearable running-sum accumulator (mod 2^W), kept separate so an
// instruction-BRAM verifier can reuse it.
module bram_dump_reader_checksum #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_q;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q + din;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/bram_dump_reader.sv
// Walks a word-aligned BRAM range through the debug read port and streams each
// word out on valid/ready with a last flag and a running checksum.
module bram_dump_reader
  import bram_dump_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = DUMP_DATA_WIDTH,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic [ADDR_WIDTH-1:0] debug_addr,
  input  logic [DATA_WIDTH-1:0] debug_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [DATA_WIDTH-1:0] checksum
);

  dump_state_e           state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] debug_addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic                  done_q;
  logic                  aborted_q;

  logic                  start_ok;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] base_aligned;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign start_ok     = start && (state_q == DUMP_IDLE || state_q == DUMP_DONE);
  // A handshake that coincides with abort is not counted.
  assign accept       = (state_q == DUMP_SEND) && m_valid_q && m_ready && !abort;
  assign base_aligned = {base_addr[ADDR_WIDTH-1:2], 2'b00};
  assign next_addr    = addr_q + ADDR_WIDTH'(WORD_BYTES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= DUMP_IDLE;
      addr_q       <= '0;
      debug_addr_q <= '0;
      remaining_q  <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DUMP_IDLE, DUMP_DONE: begin
          if (start) begin
            addr_q      <= base_aligned;
            remaining_q <= word_count;
            aborted_q   <= 1'b0;
            m_last_q    <= 1'b0;
            if (word_count == '0) begin
              state_q <= DUMP_DONE;
              done_q  <= 1'b1;
            end else begin
              debug_addr_q <= base_aligned;
              state_q      <= DUMP_READ;
            end
          end
        end
        DUMP_READ: begin
          if (abort) begin
            state_q   <= DUMP_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else begin
            m_data_q  <= debug_data;
            m_valid_q <= 1'b1;
            m_last_q  <= (remaining_q == CNT_WIDTH'(1));
            state_q   <= DUMP_SEND;
          end
        end
        DUMP_SEND: begin
          if (abort) begin
            m_valid_q <= 1'b0;
            state_q   <= DUMP_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (m_ready) begin
            m_valid_q   <= 1'b0;
            remaining_q <= remaining_q - CNT_WIDTH'(1);
            addr_q      <= next_addr;
            if (m_last_q) begin
              state_q <= DUMP_DONE;
              done_q  <= 1'b1;
            end else begin
              debug_addr_q <= next_addr;
              state_q      <= DUMP_READ;
            end
          end
        end
        default: state_q <= DUMP_IDLE;
      endcase
    end
  end

  bram_dump_reader_checksum #(
    .W(DATA_WIDTH)
  ) u_checksum (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (accept),
    .din (m_data_q),
    .sum (checksum)
  );

  assign debug_addr = debug_addr_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q == DUMP_READ) || (state_q == DUMP_SEND);
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_bram_dump_reader.sv
// Directed bench for bram_dump_reader: a behavioural BRAM answers the debug
// port, and each dump's stream, addresses and status are checked by hand.
module tb_bram_dump_reader;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, m_ready;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_count;
  logic [AW-1:0] debug_addr;
  logic [DW-1:0] debug_data;
  logic          m_valid, m_last, busy, done, aborted;
  logic [DW-1:0] m_data, checksum;

  logic [DW-1:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] got_data[$];
  bit            got_last[$];
  logic [AW-1:0] got_addr[$];
  int            lat;
  bit            stall_bad;
  bit            saw_valid;

  always #5 clk = ~clk;

  assign debug_data = mem[debug_addr[AW-1:2]];

  bram_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .debug_addr (debug_addr),
    .debug_data (debug_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .checksum   (checksum)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one dump. Outputs are observed on the falling edge; m_ready is set for
  // the coming rising edge before deciding whether a handshake will occur.
  // lat counts rising edges after the one that accepts start until done is seen.
  task automatic run_dump(input logic [AW-1:0] base, input int cnt, input bit toggle,
                          input bit poke);
    logic [DW-1:0] held;
    bit            holding;
    bit            fin;
    holding = 1'b0;
    fin     = 1'b0;
    held    = '0;
    got_data.delete();
    got_last.delete();
    got_addr.delete();
    lat       = -1;
    stall_bad = 1'b0;
    saw_valid = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    word_count = CW'(cnt);
    m_ready    = !toggle;
    for (int k = 1; k <= 200 && !fin; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 3) begin
        start      = 1'b1;
        base_addr  = 12'h100;
        word_count = CW'(7);
      end
      if (toggle) m_ready = !m_ready;
      if (holding && (!m_valid || m_data !== held)) stall_bad = 1'b1;
      holding = 1'b0;
      if (m_valid) saw_valid = 1'b1;
      if (busy && !m_valid) got_addr.push_back(debug_addr);
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
      end else if (m_valid) begin
        holding = 1'b1;
        held    = m_data;
      end
      if (done) begin
        lat = k - 1;
        fin = 1'b1;
      end
    end
    start   = 1'b0;
    m_ready = 1'b1;
    if (!fin) check("dump_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit hs_seen;
    bit done_seen;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0]    = 32'h0000_0001;
    mem[1]    = 32'h0000_0003;
    mem[2]    = 32'h0000_0005;
    mem[1023] = 32'hA5A5_A5A5;

    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    m_ready    = 1'b1;
    base_addr  = '0;
    word_count = '0;
    #12;
    check("rst_debug_addr", 32'(debug_addr), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Three words at full throughput.
    run_dump(12'h000, 3, 1'b0, 1'b0);
    check("a_words", 32'(got_data.size()), 32'd3);
    check("a_data0", got_data[0], 32'h1);
    check("a_data1", got_data[1], 32'h3);
    check("a_data2", got_data[2], 32'h5);
    check("a_last", {29'd0, got_last[0], got_last[1], got_last[2]}, 32'b001);
    check("a_addr1", 32'(got_addr[1]), 32'h004);
    check("a_addr2", 32'(got_addr[2]), 32'h008);
    check("a_done_lat", 32'(lat), 32'd6);
    check("a_checksum", checksum, 32'h9);
    @(negedge clk);
    check("a_done_pulse", 32'(done), 32'd0);
    check("a_checksum_hold", checksum, 32'h9);

    // Same dump with a toggling sink and an ignored start while busy.
    run_dump(12'h000, 3, 1'b1, 1'b1);
    check("b_words", 32'(got_data.size()), 32'd3);
    check("b_data0", got_data[0], 32'h1);
    check("b_data1", got_data[1], 32'h3);
    check("b_data2", got_data[2], 32'h5);
    check("b_stall_stable", 32'(stall_bad), 32'd0);
    check("b_checksum", checksum, 32'h9);

    // Address wrap from the top word back to zero.
    run_dump(12'hFFC, 2, 1'b0, 1'b0);
    check("c_addr0", 32'(got_addr[0]), 32'hFFC);
    check("c_addr1", 32'(got_addr[1]), 32'h000);
    check("c_checksum", checksum, 32'hA5A5_A5A6);

    // Unaligned base is forced down to a word boundary.
    run_dump(12'h006, 1, 1'b0, 1'b0);
    check("d_addr", 32'(got_addr[0]), 32'h004);
    check("d_data", got_data[0], 32'h3);
    check("d_last", 32'(got_last[0]), 32'd1);

    // Zero-length dump: done on the accepting edge, stream never driven.
    run_dump(12'h000, 0, 1'b0, 1'b0);
    check("e_done_lat", 32'(lat), 32'd0);
    check("e_no_valid", 32'(saw_valid), 32'd0);
    check("e_checksum", checksum, 32'd0);

    // Abort after the first accepted word.
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 12'h000;
    word_count = CW'(3);
    m_ready    = 1'b1;
    hs_seen    = 1'b0;
    for (int k = 0; k < 20 && !hs_seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid && m_ready) hs_seen = 1'b1;
    end
    check("f_first_hs", 32'(hs_seen), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("f_done", 32'(done), 32'd1);
    check("f_aborted", 32'(aborted), 32'd1);
    check("f_m_valid", 32'(m_valid), 32'd0);
    check("f_busy", 32'(busy), 32'd0);
    check("f_checksum", checksum, 32'h1);
    @(negedge clk);
    check("f_done_pulse", 32'(done), 32'd0);
    check("f_aborted_sticky", 32'(aborted), 32'd1);

    // A fresh start clears aborted and runs to completion.
    run_dump(12'h000, 3, 1'b0, 1'b0);
    check("g_aborted", 32'(aborted), 32'd0);
    check("g_checksum", checksum, 32'h9);

    // Reset while stalled in SEND with one word already summed.
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 12'h000;
    word_count = CW'(3);
    m_ready    = 1'b1;
    hs_seen    = 1'b0;
    for (int k = 0; k < 20 && !hs_seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid && m_ready) hs_seen = 1'b1;
    end
    @(negedge clk);
    m_ready = 1'b0;
    @(negedge clk);
    check("h_pre_valid", 32'(m_valid), 32'd1);
    check("h_pre_checksum", checksum, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("h_m_valid", 32'(m_valid), 32'd0);
    check("h_busy", 32'(busy), 32'd0);
    check("h_checksum", checksum, 32'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("h_no_done", 32'(done_seen), 32'd0);
    rst     = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
